// File: rtl/test_mode_sig_collector.sv
// test_mode_sig_collector: 16-bit MISR signature collector with settle/capture sequencing and golden compare
// clk, rst (sync, active-high); start: begin a run; din[3:0]: response word; exp_sig[15:0]: golden signature
// busy: SETTLE or CAPTURE; done: one-cycle completion pulse; pass: last compare result; sig[15:0]: MISR contents
// Define TEST_MODE_SIG_AUTO_RESTART_EN to relaunch a run straight out of DONE.
module test_mode_sig_collector #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CAPTURE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  din,
  input  logic [15:0] exp_sig,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
  localparam logic [15:0] SETTLE_LAST  = SETTLE_CYCLES == 0 ? 16'd0 : 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CAPTURE_LAST = 16'(CAPTURE_CYCLES - 1);
  localparam state_t FIRST = SETTLE_CYCLES == 0 ? CAPTURE : SETTLE;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, sig_n, exp_q, exp_n, misr;
  logic pass_n, reload, last;
  assign misr = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {12'h000, din};
  assign busy = state == SETTLE || state == CAPTURE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = sig;
    exp_n   = exp_q;
    pass_n  = pass;
    reload  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        reload = start;
        pass_n = start ? 1'b0 : pass;
      end
      SETTLE: begin
        last    = cnt == SETTLE_LAST;
        state_n = last ? CAPTURE : SETTLE;
        cnt_n   = last ? 16'd0 : cnt + 16'd1;
      end
      CAPTURE: begin
        last    = cnt == CAPTURE_LAST;
        sig_n   = misr;
        state_n = last ? DONE : CAPTURE;
        cnt_n   = last ? 16'd0 : cnt + 16'd1;
        pass_n  = last ? misr == exp_q : pass;
      end
      default: begin
`ifdef TEST_MODE_SIG_AUTO_RESTART_EN
        reload = 1'b1;
`else
        state_n = IDLE;
`endif
      end
    endcase
    if (reload) begin
      state_n = FIRST;
      cnt_n   = 16'd0;
      sig_n   = 16'hFFFF;
      exp_n   = exp_sig;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      sig   <= 16'hFFFF;
      exp_q <= 16'h0000;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sig   <= sig_n;
      exp_q <= exp_n;
      pass  <= pass_n;
    end
  end
endmodule

// File: tb/tb_test_mode_sig_collector.sv
// tb_test_mode_sig_collector: directed table-driven bench for test_mode_sig_collector
module tb_test_mode_sig_collector;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 0, start_b = 0, start_c = 0;
  logic [3:0] din_a = 0, din_b = 0, din_c = 0;
  logic [15:0] exp_a = 0, exp_b = 0, exp_c = 0;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  test_mode_sig_collector #(.SETTLE_CYCLES(4), .CAPTURE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .exp_sig(exp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .sig(sig_a));
  test_mode_sig_collector #(.SETTLE_CYCLES(0), .CAPTURE_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .exp_sig(exp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .sig(sig_b));
  test_mode_sig_collector u_c (
    .clk(clk), .rst(rst), .start(start_c), .din(din_c), .exp_sig(exp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .sig(sig_c));
  typedef struct {
    logic [3:0]  din;
    logic [15:0] exp;
    logic [15:0] sig;
    logic        pass;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  function automatic logic [15:0] misr_f(input logic [15:0] s, input logic [3:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, d};
  endfunction
  function automatic logic [3:0] pat(input int k);
    return 4'(k * 7 + 3);
  endfunction
  task automatic run_a(input logic [3:0] d, input logic [15:0] e, input logic [15:0] es,
                       input logic ep, input string nm);
    int cyc, nb;
    logic hold_ok;
    @(negedge clk);
    din_a = d; exp_a = e; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; exp_a = ~e;
    cyc = 0; nb = 0; hold_ok = 1'b1;
    while (!done_a && cyc < 20) begin
      if (busy_a) nb++;
      if (sig_a !== 16'hFFFF) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 5);
    chk({nm, "_busy_cycles"}, nb, 5);
    chk({nm, "_settle_hold"}, {31'd0, hold_ok}, 1);
    chk({nm, "_sig"}, {16'd0, sig_a}, {16'd0, es});
    chk({nm, "_pass"}, {31'd0, pass_a}, {31'd0, ep});
    @(negedge clk);
    chk({nm, "_done_width"}, {31'd0, done_a}, 0);
`ifdef TEST_MODE_SIG_AUTO_RESTART_EN
    pulse_rst();
`else
    chk({nm, "_idle_after"}, {31'd0, busy_a}, 0);
`endif
  endtask
  initial begin
    int cyc;
    logic seen;
    logic [15:0] m;
    tv[0] = '{4'h0, 16'hEFDF, 16'hEFDF, 1'b1};
    tv[1] = '{4'h0, 16'h0000, 16'hEFDF, 1'b0};
    tv[2] = '{4'h5, 16'hEFDA, 16'hEFDA, 1'b1};
    tv[3] = '{4'hA, 16'hEFD5, 16'hEFD5, 1'b1};
    tv[4] = '{4'hF, 16'hEFD0, 16'hEFD0, 1'b1};
    tv[5] = '{4'h3, 16'hEFDF, 16'hEFDC, 1'b0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sig_a", {16'd0, sig_a}, 32'hFFFF);
    chk("rst_flags_a", {29'd0, busy_a, done_a, pass_a}, 0);
    chk("rst_sig_b", {16'd0, sig_b}, 32'hFFFF);
    chk("rst_flags_c", {29'd0, busy_c, done_c, pass_c}, 0);
    for (int i = 0; i < 6; i++) run_a(tv[i].din, tv[i].exp, tv[i].sig, tv[i].pass, $sformatf("vec%0d", i));
    // start held high and exp_sig wiggled through the whole run, including DONE
    @(negedge clk);
    din_a = 4'h0; exp_a = 16'hEFDF; start_a = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done_a && cyc < 20) begin
      exp_a = 16'(cyc * 16'h1357);
      @(negedge clk);
      cyc++;
    end
    chk("restart_latency", cyc, 5);
    chk("restart_sig", {16'd0, sig_a}, 32'hEFDF);
    chk("restart_pass", {31'd0, pass_a}, 1);
    @(negedge clk);
    start_a = 1'b0;
    chk("restart_done_width", {31'd0, done_a}, 0);
`ifdef TEST_MODE_SIG_AUTO_RESTART_EN
    pulse_rst();
`else
    @(negedge clk);
    chk("done_start_ignored", {31'd0, busy_a}, 0);
    for (int i = 0; i < 3; i++) begin
      din_a = 4'(i + 5); exp_a = 16'(i);
      @(negedge clk);
    end
    chk("idle_hold_sig", {16'd0, sig_a}, 32'hEFDF);
    chk("idle_hold_pass", {31'd0, pass_a}, 1);
`endif
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk("rst_prio_busy", {31'd0, busy_a}, 0);
    chk("rst_prio_sig", {16'd0, sig_a}, 32'hFFFF);
    // zero-settle instance: capture begins on the edge after start
    @(negedge clk);
    din_b = 4'hF; exp_b = 16'hCF8E; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy0", {31'd0, busy_b}, 1);
    chk("b_sig0", {16'd0, sig_b}, 32'hFFFF);
    @(negedge clk);
    chk("b_sig1", {16'd0, sig_b}, 32'hEFD0);
    chk("b_done1", {31'd0, done_b}, 0);
    @(negedge clk);
    chk("b_done2", {31'd0, done_b}, 1);
    chk("b_sig2", {16'd0, sig_b}, 32'hCF8E);
    chk("b_pass2", {31'd0, pass_b}, 1);
    @(negedge clk);
`ifdef TEST_MODE_SIG_AUTO_RESTART_EN
    pulse_rst();
`endif
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy_b}, 0);
    chk("midrst_sig", {16'd0, sig_b}, 32'hFFFF);
    chk("midrst_pass_done", {30'd0, pass_b, done_b}, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= done_b;
      @(negedge clk);
    end
    chk("midrst_no_done", {31'd0, seen}, 0);
    // default parameters with a changing din stream; settle-window din must be ignored
    m = 16'hFFFF;
    for (int k = 5; k <= 68; k++) m = misr_f(m, pat(k));
    din_c = pat(0); exp_c = m; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 0;
    while (!done_c && cyc < 200) begin
      din_c = pat(cyc + 1);
      @(negedge clk);
      cyc++;
    end
    chk("c_latency", cyc, 68);
    chk("c_sig", {16'd0, sig_c}, {16'd0, m});
    chk("c_pass", {31'd0, pass_c}, 1);
    @(negedge clk);
`ifdef TEST_MODE_SIG_AUTO_RESTART_EN
    pulse_rst();
    din_a = 4'h0; exp_a = 16'hEFDF; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("auto_first", cyc, 5);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      cyc = 1;
      while (!done_a && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("auto_period%0d", r), cyc, 6);
      chk($sformatf("auto_pass%0d", r), {31'd0, pass_a}, 1);
    end
    pulse_rst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
